// File: rtl/shift_seq_ctrl.sv
// Serializes an N-bit word LSB-first, holding each bit for DIV clocks and
// strobing shift_en at the sampling point of each bit.
module shift_seq_ctrl #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         abort,
  output logic         serial_out,
  output logic         shift_en,
  output logic         busy,
  output logic         done
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [N-1:0]  hold_r, hold_nxt_s;
  logic [BW-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [DW-1:0] div_cnt_r, div_cnt_nxt_s;

  logic in_ready_r, serial_out_r, shift_en_r, busy_r, done_r;
  logic in_ready_s, serial_out_s, shift_en_s, busy_s, done_s;

  // Next-state, datapath and look-ahead output decode
  always_comb begin
    state_nxt_s   = state_r;
    hold_nxt_s    = hold_r;
    bit_cnt_nxt_s = bit_cnt_r;
    div_cnt_nxt_s = div_cnt_r;
    case (state_r)
      ST_IDLE: begin
        // in_ready_r gates capture so the first cycle after reset accepts nothing
        if (in_valid && in_ready_r) begin
          state_nxt_s   = ST_SHIFT;
          hold_nxt_s    = in_data;
          bit_cnt_nxt_s = {BW{1'b0}};
          div_cnt_nxt_s = {DW{1'b0}};
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_nxt_s   = ST_IDLE;
          hold_nxt_s    = {N{1'b0}};
          bit_cnt_nxt_s = {BW{1'b0}};
          div_cnt_nxt_s = {DW{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
          hold_nxt_s    = {1'b0, hold_r[N-1:1]};
          div_cnt_nxt_s = {DW{1'b0}};
          if (bit_cnt_r == BIT_LAST) begin
            state_nxt_s   = ST_DONE;
            bit_cnt_nxt_s = {BW{1'b0}};
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + BW'(1);
          end
        end else begin
          div_cnt_nxt_s = div_cnt_r + DW'(1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        hold_nxt_s    = {N{1'b0}};
        bit_cnt_nxt_s = {BW{1'b0}};
        div_cnt_nxt_s = {DW{1'b0}};
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line up with it
    in_ready_s   = (state_nxt_s == ST_IDLE);
    busy_s       = (state_nxt_s != ST_IDLE);
    done_s       = (state_nxt_s == ST_DONE);
    serial_out_s = (state_nxt_s == ST_SHIFT) ? hold_nxt_s[0] : 1'b0;
    shift_en_s   = (state_nxt_s == ST_SHIFT) && (div_cnt_nxt_s == DIV_LAST);
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      hold_r       <= {N{1'b0}};
      bit_cnt_r    <= {BW{1'b0}};
      div_cnt_r    <= {DW{1'b0}};
      in_ready_r   <= 1'b0;
      serial_out_r <= 1'b0;
      shift_en_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      hold_r       <= hold_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      div_cnt_r    <= div_cnt_nxt_s;
      in_ready_r   <= in_ready_s;
      serial_out_r <= serial_out_s;
      shift_en_r   <= shift_en_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign serial_out = serial_out_r;
  assign shift_en   = shift_en_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: an N=8/DIV=4 instance and an N=4/DIV=1 instance,
// with expected serial bits queued at capture and popped at each shift_en.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst8, in_valid8, abort8, in_ready8, serial_out8, shift_en8, busy8, done8;
  logic [7:0] in_data8;
  logic       rst4, in_valid4, abort4, in_ready4, serial_out4, shift_en4, busy4, done4;
  logic [3:0] in_data4;

  shift_seq_ctrl #(.N(8), .DIV(4)) dut8 (
    .clk(clk), .rst_n(rst8), .in_valid(in_valid8), .in_data(in_data8),
    .in_ready(in_ready8), .abort(abort8), .serial_out(serial_out8),
    .shift_en(shift_en8), .busy(busy8), .done(done8)
  );

  shift_seq_ctrl #(.N(4), .DIV(1)) dut4 (
    .clk(clk), .rst_n(rst4), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .abort(abort4), .serial_out(serial_out4),
    .shift_en(shift_en4), .busy(busy4), .done(done4)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  logic q8[$];
  logic q4[$];
  int   sen_cnt8 = 0, done_cnt8 = 0, done_prev8 = 0, done_last8 = 0;
  int   sen_cnt4 = 0, done_cnt4 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every shift_en pops the next expected bit
  task automatic mon();
    logic e;
    if (shift_en8 === 1'b1) begin
      sen_cnt8++;
      chk("sb8_avail", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("sb8_bit", 32'(serial_out8), 32'(e));
      end
    end
    if (done8 === 1'b1) begin
      done_cnt8++;
      done_prev8 = done_last8;
      done_last8 = cyc;
    end
    if (shift_en4 === 1'b1) begin
      sen_cnt4++;
      chk("sb4_avail", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("sb4_bit", 32'(serial_out4), 32'(e));
      end
    end
    if (done4 === 1'b1) done_cnt4++;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  // Present a word for one capture edge, queueing its first nb bits
  task automatic send8(input logic [7:0] d, input int nb);
    in_valid8 = 1'b1;
    in_data8  = d;
    for (int i = 0; i < nb; i++) q8.push_back(d[i]);
    tick();
    in_valid8 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] d, input int nb);
    in_valid4 = 1'b1;
    in_data4  = d;
    for (int i = 0; i < nb; i++) q4.push_back(d[i]);
    tick();
    in_valid4 = 1'b0;
  endtask

  task automatic wait_ready8(input string tag);
    for (int i = 0; i < 60 && in_ready8 !== 1'b1; i++) tick();
    chk(tag, 32'(in_ready8), 32'd1);
  endtask

  initial begin
    logic [7:0] w8;
    logic [3:0] w4;
    int s0, d0;
    rst8 = 1'b0; in_valid8 = 1'b0; in_data8 = 8'h00; abort8 = 1'b0;
    rst4 = 1'b0; in_valid4 = 1'b0; in_data4 = 4'h0; abort4 = 1'b0;

    // Reset held three cycles
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_shift_en", 32'(shift_en8), 32'd0);
    chk("rst_serial", 32'(serial_out8), 32'd0);
    chk("rst_in_ready4", 32'(in_ready4), 32'd0);
    rst8 = 1'b1;
    rst4 = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready8), 32'd1);
    chk("idle_busy", 32'(busy8), 32'd0);
    chk("idle_done", 32'(done8), 32'd0);
    chk("idle_shift_en", 32'(shift_en8), 32'd0);
    chk("idle_serial", 32'(serial_out8), 32'd0);
    chk("idle_in_ready4", 32'(in_ready4), 32'd1);

    // Single word: cycle-exact timing against capture edge k
    w8 = 8'hA5;
    d0 = done_cnt8;
    send8(w8, 8);
    for (int c = 1; c <= 34; c++) begin
      if (c > 1) tick();
      if (c <= 32) chk("a5_serial", 32'(serial_out8), 32'(w8[(c - 1) / 4]));
      chk("a5_shift_en", 32'(shift_en8), 32'((c % 4 == 0) && (c <= 32)));
      chk("a5_done", 32'(done8), 32'(c == 33));
      chk("a5_in_ready", 32'(in_ready8), 32'(c == 34));
    end
    chk("a5_done_count", 32'(done_cnt8 - d0), 32'd1);

    // Back-to-back with in_valid held high
    d0 = done_cnt8;
    in_valid8 = 1'b1;
    in_data8  = 8'h01;
    for (int i = 0; i < 8; i++) q8.push_back(1'(i == 0));
    tick();
    in_data8 = 8'h80;
    for (int i = 0; i < 8; i++) q8.push_back(1'(i == 7));
    wait_ready8("b2b_ready1");
    tick();
    in_valid8 = 1'b0;
    chk("b2b_recapture_ready", 32'(in_ready8), 32'd0);
    chk("b2b_recapture_busy", 32'(busy8), 32'd1);
    wait_ready8("b2b_ready2");
    chk("b2b_done_count", 32'(done_cnt8 - d0), 32'd2);
    chk("b2b_done_gap", 32'(done_last8 - done_prev8), 32'd34);

    // in_valid pulsed with 8'hFF while 8'h00 is shifting
    s0 = sen_cnt8;
    send8(8'h00, 8);
    repeat (4) tick();
    in_valid8 = 1'b1;
    in_data8  = 8'hFF;
    tick();
    in_valid8 = 1'b0;
    wait_ready8("ign_ready");
    chk("ign_shift_count", 32'(sen_cnt8 - s0), 32'd8);
    repeat (3) tick();
    chk("ign_not_sent", 32'(busy8), 32'd0);

    // Abort right after the third shift_en
    s0 = sen_cnt8;
    d0 = done_cnt8;
    send8(8'hA5, 3);
    for (int i = 0; i < 40 && (sen_cnt8 - s0) < 3; i++) tick();
    chk("abort_third_pulse", 32'(sen_cnt8 - s0), 32'd3);
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    chk("abort_in_ready", 32'(in_ready8), 32'd1);
    chk("abort_serial", 32'(serial_out8), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_shift_en", 32'(shift_en8), 32'd0);
    repeat (40) tick();
    chk("abort_shift_count", 32'(sen_cnt8 - s0), 32'd3);
    chk("abort_no_done", 32'(done_cnt8 - d0), 32'd0);

    // DIV=1, N=4: one bit per cycle
    w4 = 4'b1101;
    send4(w4, 4);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      chk("d1_shift_en", 32'(shift_en4), 32'(c <= 4));
      if (c <= 4) chk("d1_serial", 32'(serial_out4), 32'(w4[c - 1]));
      chk("d1_done", 32'(done4), 32'(c == 5));
      chk("d1_in_ready", 32'(in_ready4), 32'(c == 6));
    end

    // Reset asserted while bit 2 is on the line
    d0 = done_cnt4;
    send4(w4, 3);
    tick();
    tick();
    rst4 = 1'b0;
    tick();
    chk("d1rst_in_ready", 32'(in_ready4), 32'd0);
    chk("d1rst_busy", 32'(busy4), 32'd0);
    tick();
    chk("d1rst_in_ready_hold", 32'(in_ready4), 32'd0);
    rst4 = 1'b1;
    tick();
    chk("d1rst_release_ready", 32'(in_ready4), 32'd1);
    chk("d1rst_release_busy", 32'(busy4), 32'd0);
    repeat (8) tick();
    chk("d1rst_no_done", 32'(done_cnt4 - d0), 32'd0);

    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
